// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DM   = 2'd2
    } mem_owner_e;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter, master its environment.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_flush_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [BE_WIDTH-1:0]   dm_be_i;
    logic [ADDR_WIDTH-1:0] dm_addr_i;
    logic [DATA_WIDTH-1:0] dm_wdata_i;
    logic                  dm_gnt_o;
    logic                  dm_rvalid_o;
    logic [DATA_WIDTH-1:0] dm_rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// DM has priority; IF is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned LAT_W    = $clog2(MEM_LATENCY + 1);
    localparam int unsigned STV_W    = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state_q, state_d;
    mem_owner_e       owner_q, owner_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             drop_q, drop_d;
    logic             we_q, we_d;

    logic complete;
    logic can_grant;
    logic if_forced;
    logic dm_win;
    logic if_win;

    assign complete  = (state_q == ARB_BUSY) && (lat_cnt_q == LAT_W'(1));
    // Gated by rst_n so all outputs fall the moment reset asserts.
    assign can_grant = rst_n && ((state_q == ARB_IDLE) || complete);
    assign if_forced = (starve_cnt_q == STV_W'(STARVE_LIMIT)) && bus.if_req_i;
    assign dm_win    = can_grant && bus.dm_req_i && !if_forced;
    assign if_win    = can_grant && bus.if_req_i && !dm_win;

    always_comb begin
        bus.if_gnt_o    = if_win;
        bus.dm_gnt_o    = dm_win;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (dm_win) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = bus.dm_we_i;
            bus.mem_be_o    = bus.dm_be_i;
            bus.mem_addr_o  = bus.dm_addr_i;
            bus.mem_wdata_o = bus.dm_wdata_i;
        end else if (if_win) begin
            bus.mem_req_o  = 1'b1;
            bus.mem_be_o   = {BE_WIDTH{1'b1}};
            bus.mem_addr_o = bus.if_addr_i;
        end
    end

    always_comb begin
        // A flush landing in the completion cycle must still kill the response.
        bus.if_rvalid_o = complete && (owner_q == OWNER_IF) && !drop_q && !bus.if_flush_i;
        bus.dm_rvalid_o = complete && (owner_q == OWNER_DM);
        bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
        bus.dm_rdata_o  = (bus.dm_rvalid_o && !we_q) ? bus.mem_rdata_i : '0;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        we_d      = we_q;
        drop_d    = drop_q;
        if (dm_win || if_win) begin
            state_d   = ARB_BUSY;
            owner_d   = dm_win ? OWNER_DM : OWNER_IF;
            lat_cnt_d = LAT_W'(MEM_LATENCY);
            we_d      = dm_win && bus.dm_we_i;
            drop_d    = 1'b0;
        end else if (complete) begin
            state_d   = ARB_IDLE;
            owner_d   = OWNER_NONE;
            lat_cnt_d = '0;
            we_d      = 1'b0;
            drop_d    = 1'b0;
        end else if (state_q == ARB_BUSY) begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
            if (bus.if_flush_i && (owner_q == OWNER_IF)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.if_req_i || if_win) begin
            starve_cnt_d = '0;
        end else if (dm_win && (starve_cnt_q != STV_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_NONE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            drop_q       <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
            we_q         <= we_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (MEM_LATENCY 2 and 1) with directed and random traffic and
// compares every output each cycle against a transaction-level timing model.
module tb_mem_port_arbiter;
    localparam int unsigned STARVE = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr [2];
    logic [31:0] dm_addr [2];
    logic [31:0] dm_wdata[2];
    logic [3:0]  dm_be   [2];

    logic [1:0]  o_if_gnt, o_dm_gnt, o_mem_req, o_mem_we, o_if_rv, o_dm_rv;
    logic [3:0]  o_mem_be   [2];
    logic [31:0] o_mem_addr [2];
    logic [31:0] o_mem_wdata[2];
    logic [31:0] o_if_rd    [2];
    logic [31:0] o_dm_rd    [2];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'hC3A5_0F96) + 32'd17);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned LAT = (k == 0) ? 2 : 1;

        mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

        mem_port_arbiter #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .MEM_LATENCY (LAT),
            .STARVE_LIMIT(STARVE)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        assign bus.if_req_i   = if_req[k];
        assign bus.if_addr_i  = if_addr[k];
        assign bus.if_flush_i = if_flush[k];
        assign bus.dm_req_i   = dm_req[k];
        assign bus.dm_we_i    = dm_we[k];
        assign bus.dm_be_i    = dm_be[k];
        assign bus.dm_addr_i  = dm_addr[k];
        assign bus.dm_wdata_i = dm_wdata[k];

        assign o_if_gnt[k]    = bus.if_gnt_o;
        assign o_dm_gnt[k]    = bus.dm_gnt_o;
        assign o_mem_req[k]   = bus.mem_req_o;
        assign o_mem_we[k]    = bus.mem_we_o;
        assign o_mem_be[k]    = bus.mem_be_o;
        assign o_mem_addr[k]  = bus.mem_addr_o;
        assign o_mem_wdata[k] = bus.mem_wdata_o;
        assign o_if_rv[k]     = bus.if_rvalid_o;
        assign o_if_rd[k]     = bus.if_rdata_o;
        assign o_dm_rv[k]     = bus.dm_rvalid_o;
        assign o_dm_rd[k]     = bus.dm_rdata_o;

        // Memory: read data is valid exactly LAT cycles after a read request, garbage otherwise.
        logic [LAT-1:0] v_sr = '0;
        logic [31:0]    a_sr [LAT];
        always @(posedge clk) begin
            v_sr[0] <= bus.mem_req_o && !bus.mem_we_o;
            a_sr[0] <= bus.mem_addr_o;
            for (int i = 1; i < LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                a_sr[i] <= a_sr[i-1];
            end
        end
        assign bus.mem_rdata_i = v_sr[LAT-1] ? mem_data(a_sr[LAT-1]) : 32'hBAD0_BAD0;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: each transaction completes exactly lat cycles after its grant.
    int          done_c  [2];
    int          owner_m [2];
    int          starve_m[2];
    bit          drop_m  [2];
    logic [31:0] exp_d   [2];
    bit          g_if    [2];
    bit          g_dm    [2];

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[%0d] cyc %0d: got %h want %h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic        e_if, e_dm, e_ifrv, e_dmrv, e_we, comp, forced;
            logic [3:0]  e_be;
            logic [31:0] e_addr, e_wdata, e_ifrd, e_dmrd;
            e_if = 0; e_dm = 0; e_ifrv = 0; e_dmrv = 0; e_we = 0; comp = 0;
            e_be = '0; e_addr = '0; e_wdata = '0; e_ifrd = '0; e_dmrd = '0;
            if (!rst_n) begin
                done_c[k] = -1; owner_m[k] = 0; starve_m[k] = 0; drop_m[k] = 0;
            end else begin
                comp   = (done_c[k] == cyc);
                forced = (starve_m[k] >= STARVE) && if_req[k];
                e_dm   = (done_c[k] <= cyc) && dm_req[k] && !forced;
                e_if   = (done_c[k] <= cyc) && if_req[k] && !e_dm;
                if (if_flush[k] && owner_m[k] == 1) drop_m[k] = 1;
                e_ifrv = comp && owner_m[k] == 1 && !drop_m[k];
                e_dmrv = comp && owner_m[k] == 2;
                e_ifrd = e_ifrv ? exp_d[k] : 32'h0;
                e_dmrd = e_dmrv ? exp_d[k] : 32'h0;
                if (e_dm) begin
                    e_we = dm_we[k]; e_be = dm_be[k]; e_addr = dm_addr[k]; e_wdata = dm_wdata[k];
                end else if (e_if) begin
                    e_be = 4'hF; e_addr = if_addr[k];
                end
            end
            check("if_gnt", k, 32'(o_if_gnt[k]), 32'(e_if));
            check("dm_gnt", k, 32'(o_dm_gnt[k]), 32'(e_dm));
            check("mem_req", k, 32'(o_mem_req[k]), 32'(e_if | e_dm));
            check("mem_we", k, 32'(o_mem_we[k]), 32'(e_we));
            check("mem_be", k, 32'(o_mem_be[k]), 32'(e_be));
            check("mem_addr", k, o_mem_addr[k], e_addr);
            check("mem_wdata", k, o_mem_wdata[k], e_wdata);
            check("if_rvalid", k, 32'(o_if_rv[k]), 32'(e_ifrv));
            check("if_rdata", k, o_if_rd[k], e_ifrd);
            check("dm_rvalid", k, 32'(o_dm_rv[k]), 32'(e_dmrv));
            check("dm_rdata", k, o_dm_rd[k], e_dmrd);
            if (rst_n) begin
                if (!if_req[k] || e_if) starve_m[k] = 0;
                else if (e_dm && starve_m[k] < STARVE) starve_m[k]++;
                if (e_if || e_dm) begin
                    owner_m[k] = e_dm ? 2 : 1;
                    done_c[k]  = cyc + lat_of(k);
                    drop_m[k]  = 0;
                    exp_d[k]   = e_dm ? (dm_we[k] ? 32'h0 : mem_data(dm_addr[k]))
                                      : mem_data(if_addr[k]);
                end else if (comp) begin
                    owner_m[k] = 0;
                end
            end
            g_if[k] = e_if;
            g_dm[k] = e_dm;
        end
    endtask

    // One clock: check at the falling edge, then retire granted requests after the rising edge.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (g_if[k]) if_req[k] = 1'b0;
            if (g_dm[k]) dm_req[k] = 1'b0;
            g_if[k] = 0;
            g_dm[k] = 0;
        end
    endtask

    task automatic want_if(input int k, input logic [31:0] a);
        if (!if_req[k]) begin
            if_req[k]  = 1'b1;
            if_addr[k] = a;
        end
    endtask

    task automatic want_dm(input int k, input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd);
        if (!dm_req[k]) begin
            dm_req[k]   = 1'b1;
            dm_we[k]    = we;
            dm_be[k]    = be;
            dm_addr[k]  = a;
            dm_wdata[k] = wd;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        if_req = '0; if_flush = '0; dm_req = '0; dm_we = '0;
        for (int k = 0; k < 2; k++) begin
            if_addr[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0; dm_be[k] = '0;
            g_if[k] = 0; g_dm[k] = 0;
        end
        repeat (2) step();
        rst_n = 1'b1;

        // IF-only read, then a second fetch right at the completion cycle
        for (int k = 0; k < 2; k++) want_if(k, 32'h100);
        step();
        step();
        for (int k = 0; k < 2; k++) want_if(k, 32'h104);
        repeat (3) step();

        // Contention: DM load wins, IF follows
        for (int k = 0; k < 2; k++) begin
            want_if(k, 32'h108);
            want_dm(k, 1'b0, 4'hF, 32'h200, 32'h0);
        end
        repeat (6) step();

        // DM store with partial byte enables
        for (int k = 0; k < 2; k++) want_dm(k, 1'b1, 4'b0011, 32'h300, 32'h1234);
        repeat (4) step();

        // Starvation: both requesters held continuously
        for (int c = 0; c < 14; c++) begin
            for (int k = 0; k < 2; k++) begin
                want_if(k, 32'h400 + 32'(c * 4));
                want_dm(k, 1'b0, 4'hF, 32'h500 + 32'(c * 4), 32'h0);
            end
            step();
        end
        repeat (6) step();

        // Flush of an outstanding fetch; DM still granted right after
        for (int k = 0; k < 2; k++) want_if(k, 32'h140);
        step();
        if_flush = 2'b11;
        step();
        if_flush = 2'b00;
        for (int k = 0; k < 2; k++) want_dm(k, 1'b0, 4'hF, 32'h240, 32'h0);
        repeat (4) step();

        // Reset in the middle of a DM load
        for (int k = 0; k < 2; k++) want_dm(k, 1'b0, 4'hF, 32'h280, 32'h0);
        step();
        rst_n = 1'b0;
        #1;
        check_all();
        for (int k = 0; k < 2; k++) want_if(k, 32'h2C0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();

        // Random traffic with occasional flushes and resets
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 99) < 55) want_if(k, {16'h0, 14'($urandom), 2'b00});
                if ($urandom_range(0, 99) < 45)
                    want_dm(k, 1'($urandom), 4'($urandom), {16'h0, 14'($urandom), 2'b00},
                            $urandom);
                if_flush[k] = ($urandom_range(0, 99) < 8);
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                check_all();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
